nios_system_encoder_decoder: RTL and testbench

Quadrature decoder and position counter for the drive encoders, sitting as an Avalon-MM slave in the Nios system alongside the encoder reset output PIO. It synchronises and filters the raw A/B encoder channels, decodes them at x4 resolution into a signed position count, and flags illegal transitions and count overflow. The count is cleared by the `enc_clear` level that the encoder reset PIO drives, or by a software write.

---
 rtl/nios_system_encoder_decoder.sv | 189 ++++++++++++++++++
 tb/tb_nios_system_encoder_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_encoder_decoder.sv
// Quadrature decoder and signed position counter for the drive encoders,
// exposed as a four-word Avalon-MM slave (COUNT, STATUS, ERRCNT, STATE).
module nios_system_encoder_decoder #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_clear
);

  localparam int unsigned RUN_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned PRIME_N = SYNC_STAGES + FILTER_LEN;
  localparam int unsigned PRIME_W = $clog2(PRIME_N);
  localparam int unsigned ERR_W   = 16;

  localparam logic [RUN_W-1:0]       RUN_LAST  = RUN_W'(FILTER_LEN - 1);
  localparam logic [PRIME_W-1:0]     PRIME_END = PRIME_W'(PRIME_N - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] CNT_MIN   = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic [ERR_W-1:0]       ERR_SAT   = {ERR_W{1'b1}};

  localparam logic [1:0] ADDR_COUNT  = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_ERRCNT = 2'd2;
  localparam logic [1:0] ADDR_STATE  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             sync_now;   // {B, A}
  logic [1:0]             filt;       // {B, A}
  logic [1:0]             prev;       // filt delayed one cycle, for decode
  logic [RUN_W-1:0]       run_q [2];
  logic [PRIME_W-1:0]     prime_cnt;
  logic                   primed;

  logic [COUNT_WIDTH-1:0] count;
  logic                   dir;
  logic                   err;
  logic                   ovf;
  logic [ERR_W-1:0]       errcnt;

  logic       wr;
  logic       wr_count;
  logic       wr_status;
  logic       wr_errcnt;
  logic       clear_any;
  logic [1:0] delta;
  logic       step_up;
  logic       step_dn;
  logic       illegal;
  logic       wrap;
  logic       unused;

  // Map {B,A} onto its position in the forward cycle 00 -> A -> AB -> B.
  function automatic logic [1:0] quad_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  // Metastability synchronisers on the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
    end
  end

  assign sync_now = {sync_b[SYNC_STAGES-1], sync_a[SYNC_STAGES-1]};

  // Priming and per-channel run-length filter; priming loads filt and prev
  // together so the first decode after priming sees no change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed    <= 1'b0;
      prime_cnt <= '0;
      filt      <= 2'b00;
      prev      <= 2'b00;
      run_q[0]  <= '0;
      run_q[1]  <= '0;
    end else if (!primed) begin
      if (prime_cnt == PRIME_END) begin
        primed <= 1'b1;
        filt   <= sync_now;
        prev   <= sync_now;
      end else begin
        prime_cnt <= prime_cnt + PRIME_W'(1);
      end
    end else begin
      prev <= filt;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_now[ch] != filt[ch]) begin
          if (run_q[ch] == RUN_LAST) begin
            filt[ch]  <= sync_now[ch];
            run_q[ch] <= '0;
          end else begin
            run_q[ch] <= run_q[ch] + RUN_W'(1);
          end
        end else begin
          run_q[ch] <= '0;
        end
      end
    end
  end

  // Step decode and bus write strobes.
  always_comb begin
    wr        = chipselect & ~write_n;
    wr_count  = wr && (address == ADDR_COUNT);
    wr_status = wr && (address == ADDR_STATUS);
    wr_errcnt = wr && (address == ADDR_ERRCNT);
    clear_any = enc_clear | wr_count;
    delta     = quad_pos(filt) - quad_pos(prev);
    step_up   = primed && (delta == 2'd1);
    step_dn   = primed && (delta == 2'd3);
    illegal   = primed && (delta == 2'd2);
    wrap      = !clear_any && ((step_up && (count == CNT_MAX)) ||
                               (step_dn && (count == CNT_MIN)));
  end

  // Position count, direction, sticky flags and error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      dir    <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
      errcnt <= '0;
    end else begin
      if (clear_any) begin
        count <= '0;
      end else if (step_up) begin
        count <= count + COUNT_WIDTH'(1);
      end else if (step_dn) begin
        count <= count - COUNT_WIDTH'(1);
      end

      if (step_up) begin
        dir <= 1'b1;
      end else if (step_dn) begin
        dir <= 1'b0;
      end

      // A new event wins over a simultaneous write-one-to-clear.
      if (illegal) begin
        err <= 1'b1;
      end else if (wr_status && writedata[1]) begin
        err <= 1'b0;
      end

      if (wrap) begin
        ovf <= 1'b1;
      end else if (wr_status && writedata[2]) begin
        ovf <= 1'b0;
      end

      if (wr_errcnt) begin
        errcnt <= '0;
      end else if (illegal && (errcnt != ERR_SAT)) begin
        errcnt <= errcnt + ERR_W'(1);
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_COUNT:  readdata = 32'($signed(count));
      ADDR_STATUS: readdata = {29'h0, ovf, err, dir};
      ADDR_ERRCNT: readdata = {16'h0, errcnt};
      ADDR_STATE:  readdata = {29'h0, primed, filt};
      default:     readdata = 32'h0;
    endcase
  end

  assign unused = ^{writedata[31:3], writedata[0]};

endmodule

// File: tb/tb_nios_system_encoder_decoder.sv
// Self-checking bench for the encoder decoder: default instance for the main
// behaviour, an 8-bit / unfiltered instance for wrap and ERRCNT saturation.
module tb_nios_system_encoder_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address    [2];
  logic        chipselect [2];
  logic        write_n    [2];
  logic [31:0] writedata  [2];
  logic [31:0] readdata   [2];
  logic        enc_a      [2];
  logic        enc_b      [2];
  logic        enc_clear  [2];

  int checks = 0;
  int passed = 0;
  int q [2];

  always #5 clk = ~clk;

  nios_system_encoder_decoder dut (
    .clk(clk), .reset_n(reset_n), .address(address[0]), .chipselect(chipselect[0]),
    .write_n(write_n[0]), .writedata(writedata[0]), .readdata(readdata[0]),
    .enc_a(enc_a[0]), .enc_b(enc_b[0]), .enc_clear(enc_clear[0])
  );

  nios_system_encoder_decoder #(.COUNT_WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address[1]), .chipselect(chipselect[1]),
    .write_n(write_n[1]), .writedata(writedata[1]), .readdata(readdata[1]),
    .enc_a(enc_a[1]), .enc_b(enc_b[1]), .enc_clear(enc_clear[1])
  );

  typedef struct {
    logic        a;
    logic        b;
    logic [31:0] cnt;
    logic        dir;
  } vec_t;

  vec_t tv [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input int d, input logic [1:0] a, input logic [31:0] exp,
                         input string name);
    address[d] = a;
    #1;
    check(name, readdata[d], exp);
  endtask

  // Write held across exactly one rising edge, starting now.
  task automatic wr_now(input int d, input logic [1:0] a, input logic [31:0] v);
    address[d]    = a;
    writedata[d]  = v;
    chipselect[d] = 1'b1;
    write_n[d]    = 1'b0;
    @(negedge clk);
    chipselect[d] = 1'b0;
    write_n[d]    = 1'b1;
  endtask

  // Forward quadrature cycle: 00 -> A -> AB -> B, returned as {b, a}.
  function automatic logic [1:0] pins_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic set_pos(input int d, input int p);
    logic [1:0] ba;
    q[d]     = p & 3;
    ba       = pins_of(q[d]);
    enc_a[d] = ba[0];
    enc_b[d] = ba[1];
  endtask

  task automatic step(input int d, input int dirn, input int wait_n);
    set_pos(d, q[d] + dirn);
    cyc(wait_n);
  endtask

  initial begin
    logic [31:0] m_cnt;
    logic        m_dir, m_err, m_ovf, m_clr;
    logic [15:0] m_errcnt;
    int          kind, prevp, newp, dpos;

    for (int d = 0; d < 2; d++) begin
      address[d] = 2'd0; chipselect[d] = 1'b0; write_n[d] = 1'b1;
      writedata[d] = 32'h0; enc_clear[d] = 1'b0;
    end
    set_pos(0, 2);
    set_pos(1, 0);
    reset_n = 1'b0;

    // Reset state and priming with both pins high.
    cyc(3);
    chk_reg(0, 2'd0, 32'h0, "reset_count");
    chk_reg(0, 2'd1, 32'h0, "reset_status");
    chk_reg(0, 2'd3, 32'h0, "reset_state");
    reset_n = 1'b1;
    cyc(4);
    chk_reg(0, 2'd3, 32'h0, "state_before_prime");
    cyc(1);
    chk_reg(0, 2'd3, 32'h7, "state_primed");
    cyc(10);
    chk_reg(0, 2'd0, 32'h0, "prime_count");
    chk_reg(0, 2'd1, 32'h0, "prime_status");

    // Four forward cycles from 11, then three reverse edges.
    tv[0]  = '{1'b0, 1'b1, 32'd1,  1'b1};
    tv[1]  = '{1'b0, 1'b0, 32'd2,  1'b1};
    tv[2]  = '{1'b1, 1'b0, 32'd3,  1'b1};
    tv[3]  = '{1'b1, 1'b1, 32'd4,  1'b1};
    tv[4]  = '{1'b0, 1'b1, 32'd5,  1'b1};
    tv[5]  = '{1'b0, 1'b0, 32'd6,  1'b1};
    tv[6]  = '{1'b1, 1'b0, 32'd7,  1'b1};
    tv[7]  = '{1'b1, 1'b1, 32'd8,  1'b1};
    tv[8]  = '{1'b0, 1'b1, 32'd9,  1'b1};
    tv[9]  = '{1'b0, 1'b0, 32'd10, 1'b1};
    tv[10] = '{1'b1, 1'b0, 32'd11, 1'b1};
    tv[11] = '{1'b1, 1'b1, 32'd12, 1'b1};
    tv[12] = '{1'b0, 1'b1, 32'd13, 1'b1};
    tv[13] = '{1'b0, 1'b0, 32'd14, 1'b1};
    tv[14] = '{1'b1, 1'b0, 32'd15, 1'b1};
    tv[15] = '{1'b1, 1'b1, 32'd16, 1'b1};
    tv[16] = '{1'b1, 1'b0, 32'd15, 1'b0};
    tv[17] = '{1'b0, 1'b0, 32'd14, 1'b0};
    tv[18] = '{1'b0, 1'b1, 32'd13, 1'b0};
    for (int i = 0; i < 19; i++) begin
      enc_a[0] = tv[i].a;
      enc_b[0] = tv[i].b;
      cyc(8);
      chk_reg(0, 2'd0, tv[i].cnt, $sformatf("tbl_count[%0d]", i));
      chk_reg(0, 2'd1, {31'h0, tv[i].dir}, $sformatf("tbl_status[%0d]", i));
    end
    q[0] = 3;

    // Pin-to-count latency: unchanged after 5 edges, updated after 6.
    set_pos(0, 0);
    cyc(5);
    chk_reg(0, 2'd0, 32'd13, "latency_before");
    cyc(1);
    chk_reg(0, 2'd0, 32'd14, "latency_after");

    // Glitch rejection: 2-clock pulse ignored, 3-clock pulse counted both ways.
    enc_a[0] = 1'b1; cyc(2); enc_a[0] = 1'b0; cyc(10);
    chk_reg(0, 2'd0, 32'd14, "glitch2_count");
    enc_a[0] = 1'b1; cyc(3); enc_a[0] = 1'b0; cyc(4);
    chk_reg(0, 2'd0, 32'd15, "glitch3_up");
    cyc(5);
    chk_reg(0, 2'd0, 32'd14, "glitch3_down");
    chk_reg(0, 2'd1, 32'h0, "glitch3_status");

    // Illegal transitions and their same-cycle interactions with writes.
    set_pos(0, 2);
    cyc(8);
    chk_reg(0, 2'd0, 32'd14, "illegal_count");
    chk_reg(0, 2'd1, 32'h2, "illegal_status");
    chk_reg(0, 2'd2, 32'd1, "illegal_errcnt");
    wr_now(0, 2'd1, 32'h2);
    chk_reg(0, 2'd1, 32'h0, "err_w1c");
    set_pos(0, 0);
    cyc(5);
    wr_now(0, 2'd1, 32'h2);
    cyc(2);
    chk_reg(0, 2'd1, 32'h2, "err_w1c_vs_illegal");
    chk_reg(0, 2'd2, 32'd2, "errcnt_second");
    set_pos(0, 2);
    cyc(5);
    wr_now(0, 2'd2, 32'h0);
    cyc(4);
    chk_reg(0, 2'd2, 32'd0, "errcnt_wr_vs_illegal");
    chk_reg(0, 2'd0, 32'd14, "illegal_count2");
    wr_now(0, 2'd1, 32'h2);
    chk_reg(0, 2'd1, 32'h0, "err_w1c2");

    // enc_clear holds the count at 0 while decode continues.
    wr_now(0, 2'd0, 32'h0);
    for (int i = 0; i < 50; i++) step(0, 1, 8);
    chk_reg(0, 2'd0, 32'd50, "count_50");
    enc_clear[0] = 1'b1;
    cyc(2);
    chk_reg(0, 2'd0, 32'd0, "clear_level");
    step(0, 1, 8);
    chk_reg(0, 2'd0, 32'd0, "clear_step_up");
    chk_reg(0, 2'd1, 32'h1, "clear_dir_up");
    step(0, -1, 8);
    chk_reg(0, 2'd0, 32'd0, "clear_step_dn");
    chk_reg(0, 2'd1, 32'h0, "clear_dir_dn");
    enc_clear[0] = 1'b0;
    step(0, 1, 8);
    chk_reg(0, 2'd0, 32'd1, "after_clear");
    set_pos(0, q[0] + 1);
    cyc(5);
    wr_now(0, 2'd0, 32'h0);
    cyc(3);
    chk_reg(0, 2'd0, 32'd0, "wr_vs_step_count");
    chk_reg(0, 2'd1, 32'h1, "wr_vs_step_status");

    // Randomised steps against a position-level reference model.
    wr_now(0, 2'd1, 32'h6);
    wr_now(0, 2'd2, 32'h0);
    wr_now(0, 2'd0, 32'h0);
    m_cnt = 32'h0; m_dir = 1'b1; m_err = 1'b0; m_ovf = 1'b0; m_errcnt = 16'h0;
    for (int i = 0; i < 48; i++) begin
      kind  = int'($urandom_range(0, 5));
      prevp = q[0];
      case (kind)
        0, 1:    newp = prevp + 1;
        2:       newp = prevp - 1;
        3:       newp = prevp + 2;
        4:       newp = prevp;
        default: newp = ($urandom_range(0, 1) != 0) ? prevp + 1 : prevp - 1;
      endcase
      m_clr        = (kind == 5);
      enc_clear[0] = m_clr;
      set_pos(0, newp);
      cyc(8);
      enc_clear[0] = 1'b0;
      dpos = (newp - prevp) & 3;
      if (dpos == 1) begin
        m_dir = 1'b1;
        if (m_cnt == 32'h7FFF_FFFF && !m_clr) m_ovf = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end else if (dpos == 3) begin
        m_dir = 1'b0;
        if (m_cnt == 32'h8000_0000 && !m_clr) m_ovf = 1'b1;
        m_cnt = m_cnt - 32'd1;
      end else if (dpos == 2) begin
        m_err = 1'b1;
        if (m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
      end
      if (m_clr) m_cnt = 32'h0;
      chk_reg(0, 2'd0, m_cnt, $sformatf("rnd_count[%0d]", i));
      chk_reg(0, 2'd1, {29'h0, m_ovf, m_err, m_dir}, $sformatf("rnd_status[%0d]", i));
      chk_reg(0, 2'd2, {16'h0, m_errcnt}, $sformatf("rnd_errcnt[%0d]", i));
    end

    // Reset mid-operation returns everything to reset values, then re-primes.
    @(negedge clk);
    reset_n = 1'b0;
    chk_reg(0, 2'd0, 32'h0, "midreset_count");
    chk_reg(0, 2'd1, 32'h0, "midreset_status");
    chk_reg(0, 2'd2, 32'h0, "midreset_errcnt");
    chk_reg(0, 2'd3, 32'h0, "midreset_state");
    cyc(2);
    reset_n = 1'b1;
    cyc(5);
    chk_reg(0, 2'd3, {29'h0, 1'b1, pins_of(q[0])}, "reprime_state");

    // 8-bit counter: wrap in both directions sets OVF.
    for (int i = 0; i < 127; i++) step(1, 1, 4);
    cyc(4);
    chk_reg(1, 2'd0, 32'h7F, "w8_count_max");
    chk_reg(1, 2'd1, 32'h1, "w8_status_max");
    step(1, 1, 6);
    chk_reg(1, 2'd0, 32'hFFFF_FF80, "w8_wrap_up");
    chk_reg(1, 2'd1, 32'h5, "w8_ovf_up");
    wr_now(1, 2'd1, 32'h4);
    chk_reg(1, 2'd1, 32'h1, "w8_ovf_w1c");
    step(1, -1, 6);
    chk_reg(1, 2'd0, 32'h7F, "w8_wrap_dn");
    chk_reg(1, 2'd1, 32'h4, "w8_ovf_dn");
    wr_now(1, 2'd1, 32'h4);
    chk_reg(1, 2'd1, 32'h0, "w8_ovf_w1c2");

    // ERRCNT saturation: both pins flip every clock on the unfiltered instance.
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      enc_a[1] = ~enc_a[1];
      enc_b[1] = ~enc_b[1];
    end
    cyc(6);
    chk_reg(1, 2'd2, 32'hFFFF, "errcnt_saturated");
    chk_reg(1, 2'd1, 32'h2, "sat_status");
    chk_reg(1, 2'd0, 32'h7F, "sat_count");
    wr_now(1, 2'd2, 32'h0);
    chk_reg(1, 2'd2, 32'h0, "errcnt_cleared");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
